// File: rtl/view_pkg.sv
// Shared constants, trig table and saturation helper for the view rotation path.
// Used by view_rotator and sin_cos_rom; CAM_STEPS matches virtual_camera.
package view_pkg;

    localparam int CAM_STEPS  = 64;
    localparam int ANG_W      = 6;
    localparam int TRIG_ONE   = 128;
    localparam int TRIG_SHIFT = 7;
    localparam int PW_DEF     = 10;
    localparam int TW_DEF     = 9;

    // round(128*sin(2*pi*k/64)) for the first quadrant, k = 0..16
    function automatic int quarter_sin(input int k);
        int v;
        case (k)
            0:  v = 0;
            1:  v = 13;
            2:  v = 25;
            3:  v = 37;
            4:  v = 49;
            5:  v = 60;
            6:  v = 71;
            7:  v = 81;
            8:  v = 91;
            9:  v = 99;
            10: v = 106;
            11: v = 113;
            12: v = 118;
            13: v = 122;
            14: v = 126;
            15: v = 127;
            default: v = TRIG_ONE;
        endcase
        return v;
    endfunction

    function automatic int sin_entry(input int k);
        int m;
        int v;
        m = k % CAM_STEPS;
        if (m <= 16)      v = quarter_sin(m);
        else if (m <= 32) v = quarter_sin(32 - m);
        else if (m <= 48) v = -quarter_sin(m - 32);
        else              v = -quarter_sin(64 - m);
        return v;
    endfunction

    function automatic logic signed [31:0] sat_clip(input logic signed [31:0] v,
                                                    input int w);
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        logic signed [31:0] r;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -(32'sd1 <<< (w - 1));
        if (v > hi)      r = hi;
        else if (v < lo) r = lo;
        else             r = v;
        return r;
    endfunction

endpackage

// File: rtl/view_rotator_sin_cos_rom.sv
// 64-entry sine table with registered sin/cos read ports; cos reads the
// same table a quarter turn ahead.
module sin_cos_rom
    import view_pkg::*;
#(
    parameter int TW = TW_DEF
) (
    input  logic                    clk,
    input  logic                    en,
    input  logic [ANG_W-1:0]        angle,
    output logic signed [TW-1:0]    sin_q,
    output logic signed [TW-1:0]    cos_q
);

    logic signed [TW-1:0] rom [CAM_STEPS];
    logic [ANG_W-1:0]     cos_idx;

    generate
        for (genvar gi = 0; gi < CAM_STEPS; gi++) begin : g_rom
            assign rom[gi] = TW'(sin_entry(gi));
        end
    endgenerate

    assign cos_idx = angle + ANG_W'(CAM_STEPS / 4);

    always_ff @(posedge clk) begin
        if (en) begin
            sin_q <= rom[angle];
            cos_q <= rom[cos_idx];
        end
    end

endmodule

// File: rtl/view_rotator.sv
// Rotates streamed 3D points about the y axis by a per-frame latched angle.
// Define VIEW_ROT_DEPTH_EN to also compute rotated depth on out_z.
module view_rotator
    import view_pkg::*;
#(
    parameter int PW = PW_DEF,
    parameter int TW = TW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ANG_W-1:0]     camera_offset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 in_sof,
    input  logic signed [PW-1:0] in_x,
    input  logic signed [PW-1:0] in_y,
    input  logic signed [PW-1:0] in_z,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_sof,
    output logic signed [PW-1:0] out_x,
    output logic signed [PW-1:0] out_y,
    output logic signed [PW-1:0] out_z
);

    localparam int MW = PW + TW;
    localparam int SW = MW + 1;

    logic                 advance;
    logic                 accept;
    logic [ANG_W-1:0]     angle_reg;
    logic [ANG_W-1:0]     angle_sel;
    logic signed [TW-1:0] sin_q;
    logic signed [TW-1:0] cos_q;

    logic                 v1_reg, sof1_reg;
    logic signed [PW-1:0] x1_reg, y1_reg, z1_reg;
    logic                 v2_reg, sof2_reg;
    logic signed [PW-1:0] y2_reg;
    logic signed [MW-1:0] p_xc_reg, p_zs_reg;

    logic signed [SW-1:0] sum_x, shx;
    logic signed [31:0]   sat_x;

    // The whole pipeline moves in lockstep; only a held output stalls it.
    assign advance   = !(out_valid && !out_ready);
    assign in_ready  = advance;
    assign accept    = in_valid && advance;
    // A sof point already uses its own offset, not the previous frame's.
    assign angle_sel = in_sof ? camera_offset : angle_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  angle_reg <= '0;
        else if (accept && in_sof)  angle_reg <= camera_offset;
    end

    sin_cos_rom #(.TW(TW)) u_rom (
        .clk   (clk),
        .en    (accept),
        .angle (angle_sel),
        .sin_q (sin_q),
        .cos_q (cos_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v1_reg   <= 1'b0;
            sof1_reg <= 1'b0;
            x1_reg   <= '0;
            y1_reg   <= '0;
            z1_reg   <= '0;
        end else if (advance) begin
            v1_reg <= in_valid;
            if (accept) begin
                sof1_reg <= in_sof;
                x1_reg   <= in_x;
                y1_reg   <= in_y;
                z1_reg   <= in_z;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            v2_reg   <= 1'b0;
            sof2_reg <= 1'b0;
            y2_reg   <= '0;
            p_xc_reg <= '0;
            p_zs_reg <= '0;
        end else if (advance) begin
            v2_reg <= v1_reg;
            if (v1_reg) begin
                sof2_reg <= sof1_reg;
                y2_reg   <= y1_reg;
                p_xc_reg <= MW'(x1_reg) * MW'(cos_q);
                p_zs_reg <= MW'(z1_reg) * MW'(sin_q);
            end
        end
    end

    assign sum_x = SW'(p_xc_reg) + SW'(p_zs_reg);
    assign shx   = sum_x >>> TRIG_SHIFT;
    assign sat_x = sat_clip(32'(shx), PW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_x     <= '0;
            out_y     <= '0;
        end else if (advance) begin
            out_valid <= v2_reg;
            if (v2_reg) begin
                out_sof <= sof2_reg;
                out_x   <= sat_x[PW-1:0];
                out_y   <= y2_reg;
            end
        end
    end

`ifdef VIEW_ROT_DEPTH_EN
    logic signed [MW-1:0] p_zc_reg, p_xs_reg;
    logic signed [SW-1:0] sum_z, shz;
    logic signed [31:0]   sat_z;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_zc_reg <= '0;
            p_xs_reg <= '0;
        end else if (advance && v1_reg) begin
            p_zc_reg <= MW'(z1_reg) * MW'(cos_q);
            p_xs_reg <= MW'(x1_reg) * MW'(sin_q);
        end
    end

    assign sum_z = SW'(p_zc_reg) - SW'(p_xs_reg);
    assign shz   = sum_z >>> TRIG_SHIFT;
    assign sat_z = sat_clip(32'(shz), PW);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)                  out_z <= '0;
        else if (advance && v2_reg) out_z <= sat_z[PW-1:0];
    end
`else
    assign out_z = '0;
`endif

endmodule
